// File: rtl/adc_ovfl_mon_pkg.sv
// Shared constants for the multi-channel ADC overflow qualifier:
// config register select codes, decision modes and reset fill bits.
package adc_ovfl_mon_pkg;

  // cfg_sel register codes
  localparam logic [1:0] CFG_WIN_LAST = 2'd0;
  localparam logic [1:0] CFG_MASK     = 2'd1;
  localparam logic [1:0] CFG_THRESH   = 2'd2;
  localparam logic [1:0] CFG_MODE     = 2'd3;

  // Decision modes: legacy bit-mask test or count threshold
  localparam logic MODE_MASK   = 1'b0;
  localparam logic MODE_THRESH = 1'b1;

  // Reset fill bits, replicated to the configured counter width
  localparam logic WIN_LAST_RST_BIT = 1'b1;
  localparam logic MASK_RST_BIT     = 1'b1;
  localparam logic THRESH_RST_BIT   = 1'b0;

endpackage

// File: rtl/adc_ovfl_chan.sv
// One overflow channel: saturating window count, end-of-window decision,
// one-cycle qualified pulse, sticky flag and (with ADC_OVFL_PEAK_EN) the
// running peak of the per-window counts.
module adc_ovfl_chan
  import adc_ovfl_mon_pkg::*;
#(
  parameter int CTR_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample,
  input  logic                eval,
  input  logic                restart,
  input  logic [CTR_BITS-1:0] mask,
  input  logic [CTR_BITS-1:0] thresh,
  input  logic                mode,
  input  logic                clr,
  output logic                pulse,
  output logic                sticky,
  output logic [CTR_BITS-1:0] last_cnt
`ifdef ADC_OVFL_PEAK_EN
  ,
  output logic [CTR_BITS-1:0] peak
`endif
);

  localparam logic [CTR_BITS-1:0] CNT_MAX = '1;

  logic [CTR_BITS-1:0] cnt;
  logic [CTR_BITS-1:0] cnt_next;
  logic                hit;

  // Saturating count including this cycle's sample, and the decision on it
  always_comb begin
    cnt_next = (cnt == CNT_MAX) ? CNT_MAX : cnt + CTR_BITS'(sample);
    if (mode == MODE_THRESH) hit = (thresh != '0) && (cnt_next >= thresh);
    else                     hit = (cnt_next & mask) != '0;
  end

  // Window accumulation; a restart discards the window without evaluating
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      last_cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (eval) begin
      cnt      <= '0;
      last_cnt <= cnt_next;
    end else begin
      cnt <= cnt_next;
    end
  end

  // Qualified pulse and sticky flag; a set beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      pulse  <= 1'b0;
      sticky <= 1'b0;
    end else begin
      pulse <= eval && hit;
      if (eval && hit) sticky <= 1'b1;
      else if (clr)    sticky <= 1'b0;
    end
  end

`ifdef ADC_OVFL_PEAK_EN
  // Peak of window counts; clear restarts it from the coinciding window
  always_ff @(posedge clk) begin
    if (rst) begin
      peak <= '0;
    end else if (eval) begin
      if (clr || (cnt_next > peak)) peak <= cnt_next;
    end else if (clr) begin
      peak <= '0;
    end
  end
`endif

endmodule

// File: rtl/adc_ovfl_mon.sv
// Multi-channel ADC overflow qualifier (adc_clk domain). Owns the window
// counter, config registers and readback mux; per-channel logic lives in
// adc_ovfl_chan. Optional macro ADC_OVFL_PEAK_EN adds peak storage, read
// with rd_sel MSB=1; without it rd_sel MSB is ignored.
module adc_ovfl_mon
  import adc_ovfl_mon_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int CTR_BITS  = 16,
  parameter int RSEL_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       ovfl_in,
  input  logic                 cfg_wr,
  input  logic [1:0]           cfg_sel,
  input  logic [CTR_BITS-1:0]  cfg_data,
  input  logic [NCH-1:0]       clr,
  input  logic [RSEL_BITS-1:0] rd_sel,
  output logic [NCH-1:0]       ovfl_pulse,
  output logic [NCH-1:0]       ovfl_sticky,
  output logic                 win_done,
  output logic [CTR_BITS-1:0]  rd_data
);

  localparam int IDX_BITS = RSEL_BITS - 1;

  logic [CTR_BITS-1:0] wctr;
  logic [CTR_BITS-1:0] win_last;
  logic [CTR_BITS-1:0] mask;
  logic [CTR_BITS-1:0] thresh;
  logic                mode;
  logic                is_end;
  logic                restart;
  logic                eval;
  logic [IDX_BITS-1:0] rd_idx;
  logic                rd_peak;
  logic [CTR_BITS-1:0] rd_next;
  logic [CTR_BITS-1:0] last_cnt [NCH];
`ifdef ADC_OVFL_PEAK_EN
  logic [CTR_BITS-1:0] peak [NCH];
`else
  logic                unused_rd_peak;
  assign unused_rd_peak = rd_peak;
`endif

  // End-of-window detect; a WIN_LAST write overrides a coinciding end
  always_comb begin
    is_end  = (wctr == win_last);
    restart = cfg_wr && (cfg_sel == CFG_WIN_LAST);
    eval    = is_end && !restart;
    rd_idx  = rd_sel[IDX_BITS-1:0];
    rd_peak = rd_sel[RSEL_BITS-1];
  end

  // Config registers, effective the cycle after the write
  always_ff @(posedge clk) begin
    if (rst) begin
      win_last <= {CTR_BITS{WIN_LAST_RST_BIT}};
      mask     <= {CTR_BITS{MASK_RST_BIT}};
      thresh   <= {CTR_BITS{THRESH_RST_BIT}};
      mode     <= MODE_MASK;
    end else if (cfg_wr) begin
      case (cfg_sel)
        CFG_WIN_LAST: win_last <= cfg_data;
        CFG_MASK:     mask     <= cfg_data;
        CFG_THRESH:   thresh   <= cfg_data;
        CFG_MODE:     mode     <= cfg_data[0];
        default:      mode     <= mode;
      endcase
    end
  end

  // Window counter and the one-cycle done strobe following each evaluation
  always_ff @(posedge clk) begin
    if (rst) begin
      wctr     <= '0;
      win_done <= 1'b0;
    end else begin
      win_done <= eval;
      if (restart || is_end) wctr <= '0;
      else                   wctr <= wctr + CTR_BITS'(1);
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    adc_ovfl_chan #(
      .CTR_BITS (CTR_BITS)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .sample   (ovfl_in[g]),
      .eval     (eval),
      .restart  (restart),
      .mask     (mask),
      .thresh   (thresh),
      .mode     (mode),
      .clr      (clr[g]),
      .pulse    (ovfl_pulse[g]),
      .sticky   (ovfl_sticky[g]),
      .last_cnt (last_cnt[g])
`ifdef ADC_OVFL_PEAK_EN
      ,
      .peak     (peak[g])
`endif
    );
  end

  // Readback select; indices beyond the channel count read as zero
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NCH; i++) begin
      if (32'(rd_idx) == i) begin
`ifdef ADC_OVFL_PEAK_EN
        rd_next = rd_peak ? peak[i] : last_cnt[i];
`else
        rd_next = last_cnt[i];
`endif
      end
    end
  end

  // Registered readback, one cycle latency
  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= rd_next;
  end

endmodule
